seg7_reader: RTL and testbench

- Inverse of the team's hex-to-seven-segment decoder: accepts a stream of active-low 7-segment digit patterns over a valid/ready handshake.
- Converts each pattern back to a 4-bit hex nibble and assembles DIGITS nibbles into one word.
- Presents the word downstream with valid/ready and an error flag.
- Used by display loopback self-test and to recover values from captured segment buses.

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_pattern_to_hex.sv | 35 +++
 rtl/seg7_reader.sv | 129 ++++++++++++
 tb/tb_seg7_reader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment pattern reader: active-low segment codes,
// nibble width, reader FSM states and a hex-to-pattern helper for loopback checkers.
package seg7_pkg;

    localparam int NIBBLE_W = 4;

    // Active-low a..g in bits 6..0 (bit6 = a, bit0 = g)
    localparam logic [6:0] SEG7_0     = 7'h01;
    localparam logic [6:0] SEG7_1     = 7'h4F;
    localparam logic [6:0] SEG7_2     = 7'h12;
    localparam logic [6:0] SEG7_3     = 7'h06;
    localparam logic [6:0] SEG7_4     = 7'h4C;
    localparam logic [6:0] SEG7_5     = 7'h24;
    localparam logic [6:0] SEG7_6     = 7'h20;
    localparam logic [6:0] SEG7_7     = 7'h0F;
    localparam logic [6:0] SEG7_8     = 7'h00;
    localparam logic [6:0] SEG7_9     = 7'h04;
    localparam logic [6:0] SEG7_A     = 7'h08;
    localparam logic [6:0] SEG7_B     = 7'h60;
    localparam logic [6:0] SEG7_C     = 7'h72;
    localparam logic [6:0] SEG7_D     = 7'h42;
    localparam logic [6:0] SEG7_E     = 7'h30;
    localparam logic [6:0] SEG7_F     = 7'h38;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    function automatic logic [6:0] hex_to_seg7(input logic [NIBBLE_W-1:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = SEG7_0;
            4'h1:    pat = SEG7_1;
            4'h2:    pat = SEG7_2;
            4'h3:    pat = SEG7_3;
            4'h4:    pat = SEG7_4;
            4'h5:    pat = SEG7_5;
            4'h6:    pat = SEG7_6;
            4'h7:    pat = SEG7_7;
            4'h8:    pat = SEG7_8;
            4'h9:    pat = SEG7_9;
            4'hA:    pat = SEG7_A;
            4'hB:    pat = SEG7_B;
            4'hC:    pat = SEG7_C;
            4'hD:    pat = SEG7_D;
            4'hE:    pat = SEG7_E;
            default: pat = SEG7_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational active-low 7-segment pattern to hex nibble; zero latency, no handshake.
// Any pattern outside the 16 hex glyphs (blank included) yields nibble 0 with o_legal low.
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0]          i_pattern,
    output logic [NIBBLE_W-1:0] o_nibble,
    output logic                o_legal
);

    always_comb begin
        o_nibble = '0;
        o_legal  = 1'b1;
        case (i_pattern)
            SEG7_0:  o_nibble = 4'h0;
            SEG7_1:  o_nibble = 4'h1;
            SEG7_2:  o_nibble = 4'h2;
            SEG7_3:  o_nibble = 4'h3;
            SEG7_4:  o_nibble = 4'h4;
            SEG7_5:  o_nibble = 4'h5;
            SEG7_6:  o_nibble = 4'h6;
            SEG7_7:  o_nibble = 4'h7;
            SEG7_8:  o_nibble = 4'h8;
            SEG7_9:  o_nibble = 4'h9;
            SEG7_A:  o_nibble = 4'hA;
            SEG7_B:  o_nibble = 4'hB;
            SEG7_C:  o_nibble = 4'hC;
            SEG7_D:  o_nibble = 4'hD;
            SEG7_E:  o_nibble = 4'hE;
            SEG7_F:  o_nibble = 4'hF;
            default: o_legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Assembles DIGITS decoded segment patterns into a word (first digit = MSB); word_valid rises the
// cycle after the last digit, then seg_ready stays low until word_ready. SEG7_READER_DP_EN adds dp_out.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         seg_valid,
    output logic                         seg_ready,
    input  logic [7:0]                   seg_in,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [NIBBLE_W*DIGITS-1:0]   word_out,
`ifdef SEG7_READER_DP_EN
    output logic [DIGITS-1:0]            dp_out,
`endif
    output logic                         word_err
);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [3:0]                   r_cnt;
    logic [NIBBLE_W*DIGITS-1:0]   r_word;
    logic [NIBBLE_W*DIGITS-1:0]   w_word_shift;
    logic                         r_err;
    logic [NIBBLE_W-1:0]          w_nibble;
    logic                         w_legal;
    logic                         w_seg_fire;
    logic                         w_word_fire;
    logic                         w_last;

    seg7_pattern_to_hex u_decode (
        .i_pattern (seg_in[6:0]),
        .o_nibble  (w_nibble),
        .o_legal   (w_legal)
    );

    assign w_last = (r_cnt == 4'(DIGITS - 1));

    // Handshake strobes and both ready/valid outputs come only from the state register
    always_comb begin
        w_next_state = r_state;
        seg_ready    = 1'b0;
        word_valid   = 1'b0;
        w_seg_fire   = 1'b0;
        w_word_fire  = 1'b0;
        case (r_state)
            COLLECT: begin
                seg_ready  = 1'b1;
                w_seg_fire = seg_valid;
                if (seg_valid && w_last) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                word_valid  = 1'b1;
                w_word_fire = word_ready;
                if (word_ready) begin
                    w_next_state = COLLECT;
                end
            end
            default: w_next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    generate
        if (DIGITS == 1) begin : g_shift_one
            assign w_word_shift = w_nibble;
        end else begin : g_shift_many
            assign w_word_shift = {r_word[NIBBLE_W*DIGITS-NIBBLE_W-1:0], w_nibble};
        end
    endgenerate

    // word_out is not cleared on the word handshake; the next word shifts it out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_seg_fire) begin
            r_word <= w_word_shift;
            r_err  <= r_err | ~w_legal;
            r_cnt  <= r_cnt + 4'd1;
        end else if (w_word_fire) begin
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end
    end

    assign word_out = r_word;
    assign word_err = r_err;

`ifdef SEG7_READER_DP_EN
    logic [DIGITS-1:0] r_dp;
    logic [DIGITS-1:0] w_dp_shift;

    generate
        if (DIGITS == 1) begin : g_dp_one
            assign w_dp_shift = ~seg_in[7];
        end else begin : g_dp_many
            assign w_dp_shift = {r_dp[DIGITS-2:0], ~seg_in[7]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp <= '0;
        end else if (w_seg_fire) begin
            r_dp <= w_dp_shift;
        end
    end

    assign dp_out = r_dp;
`else
    logic w_unused_dp;
    assign w_unused_dp = seg_in[7];
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (DIGITS = 4): reset, handshake timing, backpressure,
// illegal patterns, async reset mid-word and a 16-code round trip with random gaps.
module tb_seg7_reader;

    localparam int DIGITS = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  seg_valid;
    logic                  seg_ready;
    logic [7:0]            seg_in;
    logic                  word_valid;
    logic                  word_ready;
    logic [4*DIGITS-1:0]   word_out;
    logic                  word_err;
`ifdef SEG7_READER_DP_EN
    logic [DIGITS-1:0]     dp_out;
`endif

    int checks = 0;
    int errors = 0;

    // Hex digit -> active-low pattern with dp inactive (bit7 = 1)
    logic [7:0]  enc [16] = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                              8'h80, 8'h84, 8'h88, 8'hE0, 8'hF2, 8'hC2, 8'hB0, 8'hB8};
    logic [15:0] exp_words [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

    always #5 clk = ~clk;

    seg7_reader #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .seg_in     (seg_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_out   (word_out),
`ifdef SEG7_READER_DP_EN
        .dp_out     (dp_out),
`endif
        .word_err   (word_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the digit's handshake edge
    task automatic send_digit(input logic [7:0] b);
        int n;
        n = 0;
        seg_in    = b;
        seg_valid = 1'b1;
        while (!seg_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!seg_ready) check_eq("seg_ready_timeout", {31'd0, seg_ready}, 32'd1);
        @(negedge clk);
        seg_valid = 1'b0;
    endtask

    task automatic send_word4(input logic [6:0] a, input logic [6:0] b,
                              input logic [6:0] c, input logic [6:0] d);
        send_digit({1'b1, a});
        send_digit({1'b1, b});
        send_digit({1'b1, c});
        send_digit({1'b1, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        rst_n      = 1'b0;
        seg_valid  = 1'b0;
        seg_in     = 8'hFF;
        word_ready = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        check_eq("rst_seg_ready", {31'd0, seg_ready}, 32'd1);
        check_eq("rst_word_valid", {31'd0, word_valid}, 32'd0);
        check_eq("rst_word_out", {16'd0, word_out}, 32'h0000);
        check_eq("rst_word_err", {31'd0, word_err}, 32'd0);
`ifdef SEG7_READER_DP_EN
        check_eq("rst_dp_out", {28'd0, dp_out}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_seg_ready", {31'd0, seg_ready}, 32'd1);
        check_eq("idle_word_valid", {31'd0, word_valid}, 32'd0);

        // Basic word, downstream always ready
        word_ready = 1'b1;
        send_digit(8'hCF);
        send_digit(8'h92);
        send_digit(8'h86);
        check_eq("t2_wv_before_last", {31'd0, word_valid}, 32'd0);
        send_digit(8'hCC);
        check_eq("t2_word_valid", {31'd0, word_valid}, 32'd1);
        check_eq("t2_word_out", {16'd0, word_out}, 32'h1234);
        check_eq("t2_word_err", {31'd0, word_err}, 32'd0);
        check_eq("t2_seg_ready_low", {31'd0, seg_ready}, 32'd0);
`ifdef SEG7_READER_DP_EN
        check_eq("t2_dp_out", {28'd0, dp_out}, 32'd0);
`endif
        @(negedge clk);
        check_eq("t2_seg_ready_back", {31'd0, seg_ready}, 32'd1);
        check_eq("t2_word_valid_drop", {31'd0, word_valid}, 32'd0);

        // Backpressure, with seg_valid pushed at the block while it holds
        word_ready = 1'b0;
        send_word4(7'h08, 7'h60, 7'h72, 7'h42);
        for (int i = 0; i < 5; i++) begin
            seg_valid = 1'b1;
            seg_in    = 8'hCF;
            check_eq("t3_hold_word", {16'd0, word_out}, 32'hABCD);
            check_eq("t3_hold_seg_ready", {31'd0, seg_ready}, 32'd0);
            check_eq("t3_hold_word_valid", {31'd0, word_valid}, 32'd1);
            @(negedge clk);
        end
        seg_valid  = 1'b0;
        word_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_release_seg_ready", {31'd0, seg_ready}, 32'd1);
        check_eq("t3_release_word_valid", {31'd0, word_valid}, 32'd0);
        check_eq("t3_word_kept", {16'd0, word_out}, 32'hABCD);

        // Illegal digit then a clean word
        send_word4(7'h01, 7'h7F, 7'h38, 7'h30);
        check_eq("t4_bad_word", {16'd0, word_out}, 32'h00FE);
        check_eq("t4_bad_err", {31'd0, word_err}, 32'd1);
        @(negedge clk);
        send_word4(7'h00, 7'h04, 7'h20, 7'h24);
        check_eq("t4_good_word", {16'd0, word_out}, 32'h8965);
        check_eq("t4_good_err", {31'd0, word_err}, 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a word
        word_ready = 1'b0;
        send_digit(8'hCF);
        send_digit(8'hFF);
        check_eq("t5_err_pre", {31'd0, word_err}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_seg_ready", {31'd0, seg_ready}, 32'd1);
        check_eq("t5_rst_word_valid", {31'd0, word_valid}, 32'd0);
        check_eq("t5_rst_word_out", {16'd0, word_out}, 32'h0000);
        check_eq("t5_rst_word_err", {31'd0, word_err}, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        send_digit(8'hB0);
        send_digit(8'hB0);
        send_digit(8'hB0);
        check_eq("t5_no_early_word", {31'd0, word_valid}, 32'd0);
        send_digit(8'hB0);
        check_eq("t5_word_out", {16'd0, word_out}, 32'hEEEE);
        check_eq("t5_word_err", {31'd0, word_err}, 32'd0);
        @(negedge clk);

        // All 16 codes with random gaps; dp asserted on the second digit of word 0
        for (int w = 0; w < 4; w++) begin
            for (int d = 0; d < 4; d++) begin
                repeat ($urandom_range(0, 2)) begin
                    word_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                b = enc[4*w + d];
                if (w == 0 && d == 1) b[7] = 1'b0;
                send_digit(b);
            end
            word_ready = 1'b0;
            check_eq("t6_word_valid", {31'd0, word_valid}, 32'd1);
            check_eq("t6_word_out", {16'd0, word_out}, {16'd0, exp_words[w]});
            check_eq("t6_word_err", {31'd0, word_err}, 32'd0);
`ifdef SEG7_READER_DP_EN
            check_eq("t6_dp_out", {28'd0, dp_out}, (w == 0) ? 32'b0100 : 32'd0);
`endif
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_eq("t6_word_stable", {16'd0, word_out}, {16'd0, exp_words[w]});
            word_ready = 1'b1;
            @(negedge clk);
            word_ready = 1'b0;
            check_eq("t6_word_taken", {31'd0, word_valid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
